// File: rtl/input_mode_controller_pkg.sv
// Shared codes for the input mode controller: modes, key-event types and data
// codes from the keypad mapper, ASCII constants and Setting-level limits.
package input_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ALPHA   = 2'd0,
        MODE_MORSE   = 2'd1,
        MODE_SETTING = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        EV_SINGLE     = 3'b000,
        EV_LONG       = 3'b001,
        EV_MULTI      = 3'b010,
        EV_MACRO      = 3'b011,
        EV_CTL_SINGLE = 3'b100,
        EV_CTL_LONG   = 3'b101,
        EV_CTL_MULTI  = 3'b110
    } ev_type_e;

    // Data codes; the event type disambiguates codes that share a value.
    localparam logic [7:0] D_DOT    = 8'h01;
    localparam logic [7:0] D_DASH   = 8'h01;
    localparam logic [7:0] D_DEL    = 8'h02;
    localparam logic [7:0] D_COMMIT = 8'h04;
    localparam logic [7:0] D_SPACE  = 8'h04;
    localparam logic [7:0] D_BACK   = 8'h10;
    localparam logic [7:0] D_EXIT   = 8'h10;
    localparam logic [7:0] D_ENTER  = 8'h20;
    localparam logic [7:0] D_NEXT   = 8'h01;
    localparam logic [7:0] D_PREV   = 8'h02;
    localparam logic [7:0] D_UP     = 8'h04;
    localparam logic [7:0] D_DOWN   = 8'h08;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_BS      = 8'h08;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    localparam logic [2:0] MAX_LEVEL = 3'd7;
    localparam logic [2:0] MAX_PAGE  = 3'd4;

endpackage

// File: rtl/input_mode_controller_morse_decoder.sv
// Combinational Morse letter decoder: element i of the letter is code[i]
// (0 = dot, 1 = dash); unknown patterns decode to '?'.
module morse_decoder
    import input_ctrl_pkg::*;
(
    input  logic [2:0] len,
    input  logic [4:0] code,
    output logic [7:0] ascii
);

    logic [4:0] bits;

    always_comb begin
        bits  = code & ~(5'h1F << len);
        ascii = ASCII_UNKNOWN;
        case (len)
            3'd1: case (bits)
                5'd0: ascii = 8'h45;  // E
                5'd1: ascii = 8'h54;  // T
                default: ascii = ASCII_UNKNOWN;
            endcase
            3'd2: case (bits)
                5'd0: ascii = 8'h49;  // I
                5'd2: ascii = 8'h41;  // A
                5'd1: ascii = 8'h4E;  // N
                5'd3: ascii = 8'h4D;  // M
                default: ascii = ASCII_UNKNOWN;
            endcase
            3'd3: case (bits)
                5'd0: ascii = 8'h53;  // S
                5'd4: ascii = 8'h55;  // U
                5'd2: ascii = 8'h52;  // R
                5'd6: ascii = 8'h57;  // W
                5'd1: ascii = 8'h44;  // D
                5'd5: ascii = 8'h4B;  // K
                5'd3: ascii = 8'h47;  // G
                5'd7: ascii = 8'h4F;  // O
                default: ascii = ASCII_UNKNOWN;
            endcase
            3'd4: case (bits)
                5'd0:  ascii = 8'h48;  // H
                5'd8:  ascii = 8'h56;  // V
                5'd4:  ascii = 8'h46;  // F
                5'd2:  ascii = 8'h4C;  // L
                5'd6:  ascii = 8'h50;  // P
                5'd14: ascii = 8'h4A;  // J
                5'd1:  ascii = 8'h42;  // B
                5'd9:  ascii = 8'h58;  // X
                5'd5:  ascii = 8'h43;  // C
                5'd13: ascii = 8'h59;  // Y
                5'd3:  ascii = 8'h5A;  // Z
                5'd11: ascii = 8'h51;  // Q
                default: ascii = ASCII_UNKNOWN;
            endcase
            3'd5: case (bits)
                5'd31: ascii = 8'h30;
                5'd30: ascii = 8'h31;
                5'd28: ascii = 8'h32;
                5'd24: ascii = 8'h33;
                5'd16: ascii = 8'h34;
                5'd0:  ascii = 8'h35;
                5'd1:  ascii = 8'h36;
                5'd3:  ascii = 8'h37;
                5'd7:  ascii = 8'h38;
                5'd15: ascii = 8'h39;
                default: ascii = ASCII_UNKNOWN;
            endcase
            default: ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/input_mode_controller.sv
// Input mode controller: turns mapped key events into ASCII characters and
// macro selects, and owns the mapper's mode, page and long-press threshold.
module input_mode_controller
    import input_ctrl_pkg::*;
#(
    parameter int unsigned BASE_TICKS  = 25_000_000,
    parameter int unsigned LEVEL_RESET = 1,
    parameter int unsigned GAP_MULT    = 3,
    parameter int unsigned MAX_ELEMS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] mapped_key,
    input  logic        key_valid,
    output logic [1:0]  mode,
    output logic [2:0]  current_state,
    output logic [31:0] timer_threshold,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic [7:0]  macro_id,
    output logic        macro_valid,
    output logic        err
);

    function automatic logic [31:0] level_ticks(input logic [2:0] lvl);
        logic [35:0] prod;
        prod = 36'(BASE_TICKS) * 36'({1'b0, lvl} + 4'd1);
        return prod[31:0];
    endfunction

    mode_e       mode_q, mode_d, saved_q, saved_d;
    logic [2:0]  page_q, page_d;
    logic [2:0]  level_q, level_d, pend_q, pend_d;
    logic [4:0]  code_q, code_d;
    logic [2:0]  len_q, len_d;
    logic        ovf_q, ovf_d;
    logic [33:0] gap_q, gap_d, gap_limit;
    logic [31:0] thr_q, thr_d;
    logic [7:0]  char_q, char_d, macro_q, macro_d;
    logic        char_vld_q, char_vld_d, macro_vld_q, macro_vld_d, err_q, err_d;

    logic [2:0]  ev_type;
    logic [7:0]  ev_data;
    logic [7:0]  dec_char;
    logic        commit, clear_buf, append, append_dash, remove;

    assign ev_type   = mapped_key[10:8];
    assign ev_data   = mapped_key[7:0];
    assign gap_limit = 34'(thr_q) * 34'(GAP_MULT);

    morse_decoder u_decoder (
        .len   (len_q),
        .code  (code_q),
        .ascii (dec_char)
    );

    always_comb begin
        mode_d      = mode_q;
        saved_d     = saved_q;
        page_d      = page_q;
        level_d     = level_q;
        pend_d      = pend_q;
        code_d      = code_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        gap_d       = gap_q;
        char_d      = char_q;
        char_vld_d  = 1'b0;
        macro_d     = macro_q;
        macro_vld_d = 1'b0;
        err_d       = 1'b0;
        commit      = 1'b0;
        clear_buf   = 1'b0;
        append      = 1'b0;
        append_dash = 1'b0;
        remove      = 1'b0;

        if (key_valid) begin
            gap_d = '0;
            if (mapped_key == '0) begin
                err_d = 1'b1;
            end else if (ev_type == EV_CTL_LONG && ev_data == D_EXIT) begin
                page_d    = 3'd0;
                clear_buf = 1'b1;
                case (mode_q)
                    MODE_ALPHA: begin
                        // Setting always hands control back to the text mode the Exit cycle started from
                        saved_d = mode_q;
                        mode_d  = MODE_MORSE;
                    end
                    MODE_MORSE: begin
                        mode_d = MODE_SETTING;
                        pend_d = level_q;
                    end
                    default: mode_d = MODE_ALPHA;
                endcase
            end else begin
                case (mode_q)
                    MODE_ALPHA: begin
                        case (ev_type)
                            EV_SINGLE: begin
                                char_d     = ev_data;
                                char_vld_d = 1'b1;
                            end
                            EV_CTL_SINGLE: begin
                                char_vld_d = 1'b1;
                                case (ev_data)
                                    D_SPACE: char_d = ASCII_SPACE;
                                    D_BACK:  char_d = ASCII_BS;
                                    D_ENTER: char_d = ASCII_CR;
                                    default: begin
                                        char_vld_d = 1'b0;
                                        err_d      = 1'b1;
                                    end
                                endcase
                            end
                            EV_CTL_MULTI: begin
                                case (ev_data)
                                    D_NEXT:  page_d = (page_q == MAX_PAGE) ? 3'd0 : page_q + 3'd1;
                                    D_PREV:  page_d = (page_q == 3'd0) ? MAX_PAGE : page_q - 3'd1;
                                    default: err_d = 1'b1;
                                endcase
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                    MODE_MORSE: begin
                        case (ev_type)
                            EV_SINGLE: begin
                                case (ev_data)
                                    D_DOT:   append = 1'b1;
                                    D_DEL:   remove = 1'b1;
                                    default: err_d = 1'b1;
                                endcase
                            end
                            EV_LONG: begin
                                if (ev_data == D_DASH) begin
                                    append      = 1'b1;
                                    append_dash = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            EV_CTL_SINGLE: begin
                                case (ev_data)
                                    D_COMMIT: commit = 1'b1;
                                    D_ENTER: begin
                                        if (len_q != 3'd0) begin
                                            commit = 1'b1;
                                        end else begin
                                            char_d     = ASCII_CR;
                                            char_vld_d = 1'b1;
                                        end
                                    end
                                    D_BACK: begin
                                        if (len_q != 3'd0) begin
                                            clear_buf = 1'b1;
                                        end else begin
                                            char_d     = ASCII_BS;
                                            char_vld_d = 1'b1;
                                        end
                                    end
                                    default: err_d = 1'b1;
                                endcase
                            end
                            EV_MACRO: begin
                                macro_d     = ev_data;
                                macro_vld_d = 1'b1;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                    MODE_SETTING: begin
                        if (ev_type == EV_SINGLE && ev_data == D_UP) begin
                            pend_d = (pend_q == MAX_LEVEL) ? pend_q : pend_q + 3'd1;
                        end else if (ev_type == EV_SINGLE && ev_data == D_DOWN) begin
                            pend_d = (pend_q == 3'd0) ? pend_q : pend_q - 3'd1;
                        end else if (ev_type == EV_CTL_SINGLE && ev_data == D_ENTER) begin
                            level_d = pend_q;
                            mode_d  = saved_q;
                        end else if (ev_type == EV_CTL_SINGLE && ev_data == D_BACK) begin
                            mode_d = saved_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (mode_q == MODE_MORSE && len_q != 3'd0) begin
            // A key in the timeout cycle takes the branch above, so it always beats the auto-commit
            if (gap_q + 34'd1 == gap_limit) begin
                commit = 1'b1;
            end else begin
                gap_d = gap_q + 34'd1;
            end
        end

        if (append) begin
            if (len_q == 3'(MAX_ELEMS)) begin
                ovf_d = 1'b1;
                err_d = 1'b1;
            end else begin
                code_d = code_q | (5'(append_dash) << len_q);
                len_d  = len_q + 3'd1;
            end
        end

        if (remove) begin
            if (len_q == 3'd0) begin
                err_d = 1'b1;
            end else begin
                code_d = code_q & ~(5'd1 << (len_q - 3'd1));
                len_d  = len_q - 3'd1;
            end
        end

        if (commit) begin
            char_d     = ovf_q ? ASCII_UNKNOWN : dec_char;
            char_vld_d = 1'b1;
            clear_buf  = 1'b1;
            gap_d      = '0;
        end

        if (clear_buf) begin
            code_d = '0;
            len_d  = '0;
            ovf_d  = 1'b0;
        end

        thr_d = level_ticks(level_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_ALPHA;
            saved_q     <= MODE_ALPHA;
            page_q      <= '0;
            level_q     <= 3'(LEVEL_RESET);
            pend_q      <= 3'(LEVEL_RESET);
            code_q      <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            gap_q       <= '0;
            thr_q       <= level_ticks(3'(LEVEL_RESET));
            char_q      <= '0;
            char_vld_q  <= 1'b0;
            macro_q     <= '0;
            macro_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            saved_q     <= saved_d;
            page_q      <= page_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            code_q      <= code_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            gap_q       <= gap_d;
            thr_q       <= thr_d;
            char_q      <= char_d;
            char_vld_q  <= char_vld_d;
            macro_q     <= macro_d;
            macro_vld_q <= macro_vld_d;
            err_q       <= err_d;
        end
    end

    assign mode            = mode_q;
    assign current_state   = page_q;
    assign timer_threshold = thr_q;
    assign char_out        = char_q;
    assign char_valid      = char_vld_q;
    assign macro_id        = macro_q;
    assign macro_valid     = macro_vld_q;
    assign err             = err_q;

endmodule

// File: tb/tb_input_mode_controller.sv
// Scoreboard bench for input_mode_controller: a behavioural reference model
// pushes the expected registered outputs for every driven cycle.
module tb_input_mode_controller;

    localparam int unsigned BASE = 10;
    localparam int unsigned LVL0 = 1;
    localparam int unsigned GM   = 3;
    localparam int unsigned ME   = 5;

    localparam logic [2:0] T_SINGLE = 3'b000, T_LONG = 3'b001, T_MACRO = 3'b011;
    localparam logic [2:0] T_CSING  = 3'b100, T_CLONG = 3'b101, T_CMULTI = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] mapped_key = '0;
    logic        key_valid = 1'b0;
    logic [1:0]  mode;
    logic [2:0]  current_state;
    logic [31:0] timer_threshold;
    logic [7:0]  char_out, macro_id;
    logic        char_valid, macro_valid, err;

    input_mode_controller #(
        .BASE_TICKS (BASE), .LEVEL_RESET (LVL0), .GAP_MULT (GM), .MAX_ELEMS (ME)
    ) dut (
        .clk (clk), .rst (rst), .mapped_key (mapped_key), .key_valid (key_valid),
        .mode (mode), .current_state (current_state), .timer_threshold (timer_threshold),
        .char_out (char_out), .char_valid (char_valid), .macro_id (macro_id),
        .macro_valid (macro_valid), .err (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [7:0]  ch;
        logic        mv;
        logic [7:0]  mac;
        logic        er;
        logic [1:0]  md;
        logic [2:0]  pg;
        logic [31:0] thr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    string morse_tab [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    // Reference model state
    int         m_mode, m_page, m_level, m_pend, m_gap;
    bit         m_elems[$];
    bit         m_ovf;
    logic [7:0] m_char, m_mac;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] ref_decode();
        string s;
        s = "";
        foreach (m_elems[i]) begin
            if (m_elems[i]) s = {s, "-"};
            else            s = {s, "."};
        end
        for (int k = 0; k < 36; k++)
            if (s == morse_tab[k]) return (k < 26) ? 8'(65 + k) : 8'(48 + k - 26);
        return 8'h3F;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_page = 0; m_level = LVL0; m_pend = LVL0; m_gap = 0;
        m_elems.delete(); m_ovf = 0; m_char = 8'h00; m_mac = 8'h00;
    endtask

    task automatic model_step(input bit v, input logic [2:0] t, input logic [7:0] d, output exp_t e);
        bit do_commit, do_clear, do_emit;
        logic [7:0] ech;
        do_commit = 0; do_clear = 0; do_emit = 0; ech = 8'h00;
        e = '0;
        if (v) begin
            m_gap = 0;
            if (t == 3'b000 && d == 8'h00) e.er = 1;
            else if (t == T_CLONG && d == 8'h10) begin
                if (m_mode == 0) m_mode = 1;
                else if (m_mode == 1) begin m_mode = 2; m_pend = m_level; end
                else m_mode = 0;
                m_page = 0; do_clear = 1;
            end else if (m_mode == 0) begin
                if (t == T_SINGLE) begin do_emit = 1; ech = d; end
                else if (t == T_CSING && d == 8'h04) begin do_emit = 1; ech = 8'h20; end
                else if (t == T_CSING && d == 8'h10) begin do_emit = 1; ech = 8'h08; end
                else if (t == T_CSING && d == 8'h20) begin do_emit = 1; ech = 8'h0D; end
                else if (t == T_CMULTI && d == 8'h01) m_page = (m_page + 1) % 5;
                else if (t == T_CMULTI && d == 8'h02) m_page = (m_page + 4) % 5;
                else e.er = 1;
            end else if (m_mode == 1) begin
                if ((t == T_SINGLE || t == T_LONG) && d == 8'h01) begin
                    if (m_elems.size() == ME) begin m_ovf = 1; e.er = 1; end
                    else m_elems.push_back(t == T_LONG);
                end else if (t == T_SINGLE && d == 8'h02) begin
                    if (m_elems.size() == 0) e.er = 1;
                    else void'(m_elems.pop_back());
                end else if (t == T_CSING && d == 8'h04) do_commit = 1;
                else if (t == T_CSING && d == 8'h20) begin
                    if (m_elems.size() > 0) do_commit = 1;
                    else begin do_emit = 1; ech = 8'h0D; end
                end else if (t == T_CSING && d == 8'h10) begin
                    if (m_elems.size() > 0) do_clear = 1;
                    else begin do_emit = 1; ech = 8'h08; end
                end else if (t == T_MACRO) begin m_mac = d; e.mv = 1; end
                else e.er = 1;
            end else begin
                if (t == T_SINGLE && d == 8'h04) m_pend = (m_pend < 7) ? m_pend + 1 : 7;
                else if (t == T_SINGLE && d == 8'h08) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
                else if (t == T_CSING && d == 8'h20) begin m_level = m_pend; m_mode = 0; end
                else if (t == T_CSING && d == 8'h10) m_mode = 0;
                else e.er = 1;
            end
        end else if (m_mode == 1 && m_elems.size() > 0) begin
            m_gap++;
            if (m_gap == int'(BASE * (m_level + 1) * GM)) do_commit = 1;
        end
        if (do_commit) begin do_emit = 1; ech = m_ovf ? 8'h3F : ref_decode(); do_clear = 1; end
        if (do_clear) begin m_elems.delete(); m_ovf = 0; m_gap = 0; end
        if (do_emit) begin m_char = ech; e.cv = 1; end
        e.ch = m_char; e.mac = m_mac; e.md = 2'(m_mode); e.pg = 3'(m_page);
        e.thr = BASE * (m_level + 1);
    endtask

    task automatic step(input bit v, input logic [2:0] t, input logic [7:0] d);
        exp_t e, q;
        @(negedge clk);
        key_valid  = v;
        mapped_key = v ? {t, d} : 11'h000;
        model_step(v, t, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        q = sb.pop_front();
        check_val("char_valid", char_valid, q.cv);
        check_val("char_out", char_out, q.ch);
        check_val("macro_valid", macro_valid, q.mv);
        check_val("macro_id", macro_id, q.mac);
        check_val("err", err, q.er);
        check_val("mode", mode, q.md);
        check_val("current_state", current_state, q.pg);
        check_val("timer_threshold", timer_threshold, q.thr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_val("rst_mode", mode, 0);
        check_val("rst_state", current_state, 0);
        check_val("rst_threshold", timer_threshold, 20);
        check_val("rst_strobes", {char_valid, macro_valid, err}, 0);
        check_val("rst_char_macro", {char_out, macro_id}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [10:0] ev_tab [0:15] = '{
        {3'd0, 8'h01}, {3'd1, 8'h01}, {3'd0, 8'h02}, {3'd4, 8'h04},
        {3'd4, 8'h20}, {3'd4, 8'h10}, {3'd3, 8'h08}, {3'd5, 8'h10},
        {3'd0, 8'h04}, {3'd0, 8'h08}, {3'd6, 8'h01}, {3'd6, 8'h02},
        {3'd0, 8'h41}, {3'd2, 8'h05}, 11'h000,       {3'd7, 8'h33}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] ev;
        model_reset();
        do_reset();

        // Alpha: page wrap and literal character
        step(1, T_CMULTI, 8'h02);
        check_val("alpha_prev_wrap", current_state, 4);
        step(1, T_SINGLE, 8'h57);
        check_val("alpha_char", {char_valid, char_out}, {1'b1, 8'h57});
        idle(1);

        // Morse: dot-dash commit, then overflow
        step(1, T_CLONG, 8'h10);
        step(1, T_SINGLE, 8'h01);
        step(1, T_LONG, 8'h01);
        step(1, T_CSING, 8'h04);
        check_val("morse_A", {char_valid, char_out}, {1'b1, 8'h41});
        for (int i = 0; i < 6; i++) step(1, T_SINGLE, 8'h01);
        check_val("overflow_err", err, 1);
        step(1, T_CSING, 8'h04);
        check_val("overflow_commit", char_out, 8'h3F);

        // Gap timeout, and a key landing exactly in the timeout cycle
        step(1, T_SINGLE, 8'h01);
        idle(60);
        check_val("gap_E", {char_valid, char_out}, {1'b1, 8'h45});
        step(1, T_SINGLE, 8'h01);
        idle(59);
        step(1, T_LONG, 8'h01);
        check_val("gap_key_wins", char_valid, 0);
        idle(60);
        check_val("gap_A", {char_valid, char_out}, {1'b1, 8'h41});

        // Exit with pending elements discards them
        step(1, T_SINGLE, 8'h01);
        step(1, T_SINGLE, 8'h01);
        step(1, T_LONG, 8'h01);
        step(1, T_CLONG, 8'h10);
        check_val("exit_pending", {mode, char_valid}, {2'd2, 1'b0});
        step(1, T_CSING, 8'h10);

        // Setting: saturating Up then Enter; Down then Back
        step(1, T_CLONG, 8'h10);
        step(1, T_CLONG, 8'h10);
        for (int i = 0; i < 9; i++) step(1, T_SINGLE, 8'h04);
        step(1, T_CSING, 8'h20);
        check_val("setting_enter", {mode, timer_threshold}, {2'd0, 32'd80});
        step(1, T_CLONG, 8'h10);
        step(1, T_CLONG, 8'h10);
        for (int i = 0; i < 3; i++) step(1, T_SINGLE, 8'h08);
        step(1, T_CSING, 8'h10);
        check_val("setting_back", {mode, timer_threshold}, {2'd0, 32'd80});

        // Invalid code, macro
        step(1, 3'd0, 8'h00);
        check_val("invalid_err", {err, char_valid, mode}, {1'b1, 1'b0, 2'd0});
        step(1, T_CLONG, 8'h10);
        step(1, T_MACRO, 8'h04);
        check_val("macro", {macro_valid, macro_id}, {1'b1, 8'h04});

        // Randomised event mix
        for (int n = 0; n < 400; n++) begin
            ev = ev_tab[$urandom_range(0, 15)];
            step(1, ev[10:8], ev[7:0]);
            if ($urandom_range(0, 15) == 0) idle(250);
            else idle($urandom_range(0, 3));
        end

        // Reset mid-letter and mid-setting
        while (m_mode != 1) step(1, T_CLONG, 8'h10);
        step(1, T_SINGLE, 8'h01);
        step(1, T_LONG, 8'h01);
        do_reset();
        idle(70);
        step(1, T_CLONG, 8'h10);
        step(1, T_CLONG, 8'h10);
        for (int i = 0; i < 3; i++) step(1, T_SINGLE, 8'h04);
        do_reset();
        idle(3);

        check_val("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
